// File: rtl/arm_pkg.sv
// Shared LEGv8 datapath constants and types for the register-select stage.
// Contents: address/instruction widths, XZR index, register field positions,
// the register-address type and a zero-register compare helper.
package arm_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int INSTR_W    = 32;

  // Register field LSB positions within an R/D/CB-format instruction word
  localparam int RM_LSB = 16;
  localparam int RN_LSB = 5;
  localparam int RD_LSB = 0;
  // Rt of stores and CBZ occupies the same bits as Rd
  localparam int RT_LSB = RD_LSB;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t XZR_IDX = 5'd31;

  function automatic logic is_xzr(input reg_addr_t addr);
    return (addr == XZR_IDX);
  endfunction

endpackage

// File: rtl/mux_2_1_5_reg_sel_decode.sv
// Combinational register-address extraction for the register-select stage.
// Pure bit slicing of the instruction word plus the Reg2Loc mux for port 2.
// Ports:
//   instruction  in  32  instruction word
//   reg2loc      in  1   0: port 2 reads Rm, 1: port 2 reads Rt
//   rs1_o        out 5   Rn
//   rs2_o        out 5   Rm or Rt
//   ws_o         out 5   Rd/Rt
module reg_sel_decode
  import arm_pkg::*;
(
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  reg2loc,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] ws_o
);

  reg_addr_t rn, rm, rt;

  assign rn = instruction[RN_LSB +: REG_ADDR_W];
  assign rm = instruction[RM_LSB +: REG_ADDR_W];
  assign rt = instruction[RT_LSB +: REG_ADDR_W];

  assign rs1_o = rn;
  assign rs2_o = reg2loc ? rt : rm;
  assign ws_o  = rt;

  // Opcode and immediate/shamt bits are intentionally ignored by this stage
  logic unused_fields;
  assign unused_fields = ^{instruction[31:21], instruction[15:10]};

endmodule

// File: rtl/mux_2_1_5.sv
// Register-select stage of the single-cycle LEGv8 datapath.
// Captures Rn, Rm/Rt and Rd/Rt from a qualified instruction into registers
// that drive the register-file address ports one cycle later.
// Optional feature macro: MUX_2_1_5_XZR_FLAG_EN adds registered flags that
// mark each select as the zero register (X31).
// Ports:
//   CLK          in  1   rising-edge clock
//   Reset_n      in  1   asynchronous active-low reset
//   Instruction  in  32  instruction word
//   Reg2Loc      in  1   port-2 source select (0: Rm, 1: Rt)
//   InstrValid   in  1   qualifies Instruction/Reg2Loc for capture
//   ReadSelect1  out 5   read port 1 address
//   ReadSelect2  out 5   read port 2 address
//   WriteSelect  out 5   write port address
//   SelValid     out 1   selects hold an instruction captured last edge
//   Sel1IsXzr, Sel2IsXzr, WrIsXzr  out 1  (MUX_2_1_5_XZR_FLAG_EN only)
module mux_2_1_5
  import arm_pkg::*;
(
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [INSTR_W-1:0]    Instruction,
  input  logic                  Reg2Loc,
  input  logic                  InstrValid,
  output logic [REG_ADDR_W-1:0] ReadSelect1,
  output logic [REG_ADDR_W-1:0] ReadSelect2,
  output logic [REG_ADDR_W-1:0] WriteSelect,
`ifdef MUX_2_1_5_XZR_FLAG_EN
  output logic                  Sel1IsXzr,
  output logic                  Sel2IsXzr,
  output logic                  WrIsXzr,
`endif
  output logic                  SelValid
);

  reg_addr_t rs1_d, rs2_d, ws_d;
  reg_addr_t rs1_q, rs2_q, ws_q;
  logic      valid_q;

  reg_sel_decode u_decode (
    .instruction (Instruction),
    .reg2loc     (Reg2Loc),
    .rs1_o       (rs1_d),
    .rs2_o       (rs2_d),
    .ws_o        (ws_d)
  );

  // Selects hold across idle cycles; only the valid flag drops
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      ws_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= InstrValid;
      if (InstrValid) begin
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
        ws_q  <= ws_d;
      end
    end
  end

  assign ReadSelect1 = rs1_q;
  assign ReadSelect2 = rs2_q;
  assign WriteSelect = ws_q;
  assign SelValid    = valid_q;

`ifdef MUX_2_1_5_XZR_FLAG_EN
  logic xzr1_q, xzr2_q, xzrw_q;

  // Flags are computed from the next-state selects so they line up with them
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      xzr1_q <= 1'b0;
      xzr2_q <= 1'b0;
      xzrw_q <= 1'b0;
    end else if (InstrValid) begin
      xzr1_q <= is_xzr(rs1_d);
      xzr2_q <= is_xzr(rs2_d);
      xzrw_q <= is_xzr(ws_d);
    end
  end

  assign Sel1IsXzr = xzr1_q;
  assign Sel2IsXzr = xzr2_q;
  assign WrIsXzr   = xzrw_q;
`endif

endmodule

// File: tb/tb_mux_2_1_5.sv
module tb_mux_2_1_5;

  logic        CLK;
  logic        Reset_n;
  logic [31:0] Instruction;
  logic        Reg2Loc;
  logic        InstrValid;
  logic [4:0]  ReadSelect1, ReadSelect2, WriteSelect;
  logic        SelValid;
`ifdef MUX_2_1_5_XZR_FLAG_EN
  logic        Sel1IsXzr, Sel2IsXzr, WrIsXzr;
`endif

  int total = 0;
  int bad   = 0;

  mux_2_1_5 dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .Instruction (Instruction),
    .Reg2Loc     (Reg2Loc),
    .InstrValid  (InstrValid),
    .ReadSelect1 (ReadSelect1),
    .ReadSelect2 (ReadSelect2),
    .WriteSelect (WriteSelect),
`ifdef MUX_2_1_5_XZR_FLAG_EN
    .Sel1IsXzr   (Sel1IsXzr),
    .Sel2IsXzr   (Sel2IsXzr),
    .WrIsXzr     (WrIsXzr),
`endif
    .SelValid    (SelValid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge and settle before sampling
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic r2l, input logic vld);
    Instruction = ins;
    Reg2Loc     = r2l;
    InstrValid  = vld;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive(32'hFFFF_FFFF, 1'b1, 1'b1);
    #2;
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== 16'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0000", {ReadSelect1, ReadSelect2, WriteSelect, SelValid});
    end
    // Held in reset across an edge with a valid instruction: nothing captured
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0000", {ReadSelect1, ReadSelect2, WriteSelect, SelValid});
    end
  endtask

  task automatic test_reset_release();
    drive(32'h8B05_0086, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== 16'h0) begin
      bad++;
      $display("FAIL release_idle got=%h exp=0000", {ReadSelect1, ReadSelect2, WriteSelect, SelValid});
    end
  endtask

  task automatic test_add();
    // ADD X6, X4, X5
    drive(32'h8B05_0086, 1'b0, 1'b1);
    total++;
    if (SelValid !== 1'b0) begin
      bad++;
      $display("FAIL add_latency got=%0d exp=0", SelValid);
    end
    step();
    total++;
    if (ReadSelect1 !== 5'd4) begin bad++; $display("FAIL add_rs1 got=%0d exp=4", ReadSelect1); end
    total++;
    if (ReadSelect2 !== 5'd5) begin bad++; $display("FAIL add_rs2 got=%0d exp=5", ReadSelect2); end
    total++;
    if (WriteSelect !== 5'd6) begin bad++; $display("FAIL add_ws got=%0d exp=6", WriteSelect); end
    total++;
    if (SelValid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0d exp=1", SelValid); end
  endtask

  task automatic test_reg2loc();
    // Rm=0, Rn=6, Rd=30, Reg2Loc=0
    drive(32'b11110010100_0000000000000110_11110, 1'b0, 1'b1);
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect} !== {5'd6, 5'd0, 5'd30}) begin
      bad++;
      $display("FAIL rm_sel got=%0d/%0d/%0d exp=6/0/30", ReadSelect1, ReadSelect2, WriteSelect);
    end
    // Rt=2, Rn=4, Reg2Loc=1 -> port 2 reads Rt
    drive(32'b11110010100_0000000000000100_00010, 1'b1, 1'b1);
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect} !== {5'd4, 5'd2, 5'd2}) begin
      bad++;
      $display("FAIL rt_sel got=%0d/%0d/%0d exp=4/2/2", ReadSelect1, ReadSelect2, WriteSelect);
    end
    // Rm field nonzero but ignored when Reg2Loc=1
    drive(32'h0013_0029, 1'b1, 1'b1);
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect} !== {5'd1, 5'd9, 5'd9}) begin
      bad++;
      $display("FAIL rt_ignores_rm got=%0d/%0d/%0d exp=1/9/9", ReadSelect1, ReadSelect2, WriteSelect);
    end
  endtask

  task automatic test_hold();
    drive(32'b11110010100_0000000000000100_00011, 1'b0, 1'b1);
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== {5'd4, 5'd0, 5'd3, 1'b1}) begin
      bad++;
      $display("FAIL hold_load got=%0d/%0d/%0d/%0d exp=4/0/3/1", ReadSelect1, ReadSelect2, WriteSelect, SelValid);
    end
    drive(32'h8B1F_03FF, 1'b1, 1'b0);
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== {5'd4, 5'd0, 5'd3, 1'b0}) begin
      bad++;
      $display("FAIL hold_idle got=%0d/%0d/%0d/%0d exp=4/0/3/0", ReadSelect1, ReadSelect2, WriteSelect, SelValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h0011_0022, 32'h001F_03E1, 32'hFFE0_FC1F, 32'h0005_0086};
    logic        r2l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [14:0] exp [4] = '{{5'd1, 5'd17, 5'd2},
                             {5'd31, 5'd31, 5'd1},
                             {5'd0, 5'd31, 5'd31},
                             {5'd4, 5'd6, 5'd6}};
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], r2l[i], 1'b1);
      step();
      total++;
      if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== {exp[i], 1'b1}) begin
        bad++;
        $display("FAIL b2b_%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/1", i,
                 ReadSelect1, ReadSelect2, WriteSelect, SelValid,
                 exp[i][14:10], exp[i][9:5], exp[i][4:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(32'h8B05_0086, 1'b0, 1'b1);
    step();
    drive(32'h001F_03E1, 1'b0, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== 16'h0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0000", {ReadSelect1, ReadSelect2, WriteSelect, SelValid});
    end
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== 16'h0) begin
      bad++;
      $display("FAIL reset_discard got=%h exp=0000", {ReadSelect1, ReadSelect2, WriteSelect, SelValid});
    end
    #2;
    Reset_n = 1'b1;
    step();
    total++;
    if ({ReadSelect1, ReadSelect2, WriteSelect, SelValid} !== {5'd31, 5'd31, 5'd1, 1'b1}) begin
      bad++;
      $display("FAIL first_capture got=%0d/%0d/%0d/%0d exp=31/31/1/1", ReadSelect1, ReadSelect2, WriteSelect, SelValid);
    end
  endtask

`ifdef MUX_2_1_5_XZR_FLAG_EN
  task automatic test_xzr();
    drive(32'h0000_03FF, 1'b1, 1'b1);
    step();
    total++;
    if ({Sel1IsXzr, Sel2IsXzr, WrIsXzr} !== 3'b111) begin
      bad++;
      $display("FAIL xzr_all got=%b exp=111", {Sel1IsXzr, Sel2IsXzr, WrIsXzr});
    end
    drive(32'h0000_007F, 1'b1, 1'b1);
    step();
    total++;
    if ({Sel1IsXzr, Sel2IsXzr, WrIsXzr} !== 3'b011) begin
      bad++;
      $display("FAIL xzr_rn3 got=%b exp=011", {Sel1IsXzr, Sel2IsXzr, WrIsXzr});
    end
    drive(32'h001F_0000, 1'b0, 1'b1);
    step();
    total++;
    if ({Sel1IsXzr, Sel2IsXzr, WrIsXzr} !== 3'b010) begin
      bad++;
      $display("FAIL xzr_rm got=%b exp=010", {Sel1IsXzr, Sel2IsXzr, WrIsXzr});
    end
    drive(32'h0000_0000, 1'b0, 1'b0);
    step();
    total++;
    if ({Sel1IsXzr, Sel2IsXzr, WrIsXzr} !== 3'b010) begin
      bad++;
      $display("FAIL xzr_hold got=%b exp=010", {Sel1IsXzr, Sel2IsXzr, WrIsXzr});
    end
    #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if ({Sel1IsXzr, Sel2IsXzr, WrIsXzr} !== 3'b000) begin
      bad++;
      $display("FAIL xzr_reset got=%b exp=000", {Sel1IsXzr, Sel2IsXzr, WrIsXzr});
    end
    Reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_release();
    test_add();
    test_reg2loc();
    test_hold();
    test_back_to_back();
    test_async_reset();
`ifdef MUX_2_1_5_XZR_FLAG_EN
    test_xzr();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
